plab4_net_router_input_queue_sep: RTL and testbench
===================================================

Name: plab4_net_router_input_queue_sep

Overview:
- Per-input-port buffering stage that sits directly upstream of the separated-domain round-robin input control.
- Accepts network messages tagged with a security-domain bit and steers each into one of two physically separate FIFOs (domain1 / domain2).
- Presents each FIFO head's valid and destination to the input control, and dequeues on that control's ready.
- Generates the alternating domain phase signal `fclk` that the arbitration stage uses to time-multiplex domains.

Parameters:
- p_msg_nbits, 32, width of one network message.
- p_num_routers, 8, number of routers; sets dest field width.
- p_num_entries, 4, depth of each per-domain FIFO; must be ≥2, any integer.
- c_dest_nbits, $clog2(p_num_routers), derived; not set externally. Dest field = in_msg[p_msg_nbits-1 -: c_dest_nbits].
- c_cnt_nbits, $clog2(p_num_entries+1), derived; occupancy counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  1  upstream message valid.
- in_rdy  output  1  upstream ready, for the domain selected by in_domain.
- in_msg  input  p_msg_nbits  incoming message.
- in_domain  input  1  0 = domain1, 1 = domain2.
- out_val_d1  output  1  domain1 FIFO non-empty.
- out_rdy_d1  input  1  domain1 head consumed (in_rdy_d1 of input ctrl).
- out_msg_d1  output  p_msg_nbits  domain1 head message.
- dest_d1  output  c_dest_nbits  dest field of out_msg_d1.
- out_val_d2, out_rdy_d2, out_msg_d2, dest_d2: same as the d1 ports, for domain2.
- fclk  output  1  domain phase: 0 = domain1 slot, 1 = domain2 slot.
- count_d1  output  c_cnt_nbits  domain1 occupancy.
- count_d2  output  c_cnt_nbits  domain2 occupancy.

Behaviour:
- Reset, asynchronous, effective immediately:
  - enq/deq pointers and counts of both FIFOs cleared to 0.
  - fclk = 0.
  - out_val_d1 = out_val_d2 = 0.
  - in_rdy = 0 while reset is high.
  - Storage contents undefined; out_msg/dest are don't-care while out_val = 0.
- Reset mid-operation: all buffered messages are dropped, with no partial state. The first cycle after deassertion behaves as post-reset empty.
- fclk toggles every rising edge after reset deasserts (0,1,0,1...), independent of traffic.
- in_rdy = !full of the FIFO selected by in_domain (full: count == p_num_entries).
  - No dependence on out_rdy_*: a full queue does not accept even if it dequeues the same cycle. This avoids a combinational ready loop.
- Enqueue fires when in_val & in_rdy: in_msg is written at the selected FIFO's enq pointer; pointer increments, wrapping from p_num_entries-1 to 0.
- Dequeue fires per domain when out_val_dX & out_rdy_dX: deq pointer increments with the same wrap rule.
  - out_rdy_dX asserted while out_val_dX = 0 is ignored.
- Counts:
  - enq only: +1.
  - deq only: −1.
  - enq and deq on the same FIFO in the same cycle: unchanged, both pointers advance.
  - Activity on one domain never alters the other domain's pointers or count.
- No bypass: a message enqueued at edge N is first visible on out_val/out_msg after edge N (minimum latency 1 cycle). An empty FIFO never forwards in_msg combinationally.
- out_msg_dX = storage[deq_ptr_dX]; dest_dX = out_msg_dX[p_msg_nbits-1 -: c_dest_nbits].
- out_val_dX = (count_dX != 0).
- Order: strict FIFO per domain. There is no ordering relation between domains.
- X-safety: with in_val = 0, in_domain and in_msg may be X without corrupting state.

Test Plan:
- Reset, then in_val = 0 for 4 cycles:
  - out_val_d1 = out_val_d2 = 0 and count_d1 = count_d2 = 0 throughout.
  - fclk sequence 0,1,0,1.
- Enqueue msgs 0xE000_0001..0xE000_0004 with in_domain = 0 and out_rdy_d1 = 0:
  - count_d1 reaches 4, then in_rdy = 0 for domain 0.
  - in_rdy = 1 when in_domain = 1.
  - dest_d1 = 3'b111 with head 0xE000_0001.
- Queue d1 full, then in_val = 1 with in_domain = 0 and out_rdy_d1 = 1 in the same cycle:
  - No enqueue; count_d1 goes 4 → 3.
  - Head becomes 0xE000_0002.
- d2 holds 1 entry; enq to d2 and out_rdy_d2 = 1 in the same cycle:
  - count_d2 stays 1 and the new message becomes head next cycle.
  - Across 5 enq/deq cycles the pointers wrap past entry 3 with no loss.
- Interleaved enqueues d1: A, d2: B, d1: C with no dequeue:
  - out_msg_d1 = A, out_msg_d2 = B.
  - Dequeuing d1 yields A then C; count_d2 is unaffected.
- Fill d1 with 2 msgs, assert reset asynchronously mid-cycle:
  - out_val_d1 drops before the next clock edge and fclk = 0.
  - After release, count_d1 = 0.

Source files
------------

// File: rtl/plab4_net_router_input_queue_sep.sv
// Per-input-port buffer that steers each message into one of two per-domain FIFOs.
// It also generates the alternating domain phase (fclk) used by the arbitration stage.
module plab4_net_router_input_queue_sep #(
    parameter int p_msg_nbits   = 32,
    parameter int p_num_routers = 8,
    parameter int p_num_entries = 4,
    localparam int c_dest_nbits = $clog2(p_num_routers),
    localparam int c_cnt_nbits  = $clog2(p_num_entries + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [p_msg_nbits-1:0]  in_msg,
    input  logic                    in_domain,
    output logic                    out_val_d1,
    input  logic                    out_rdy_d1,
    output logic [p_msg_nbits-1:0]  out_msg_d1,
    output logic [c_dest_nbits-1:0] dest_d1,
    output logic                    out_val_d2,
    input  logic                    out_rdy_d2,
    output logic [p_msg_nbits-1:0]  out_msg_d2,
    output logic [c_dest_nbits-1:0] dest_d2,
    output logic                    fclk,
    output logic [c_cnt_nbits-1:0]  count_d1,
    output logic [c_cnt_nbits-1:0]  count_d2
);

    localparam int c_ptr_nbits = $clog2(p_num_entries);
    localparam logic [c_ptr_nbits-1:0] c_last_ptr = c_ptr_nbits'(p_num_entries - 1);
    localparam logic [c_cnt_nbits-1:0] c_full_cnt = c_cnt_nbits'(p_num_entries);

    logic [p_msg_nbits-1:0] mem     [2][p_num_entries];
    logic [c_ptr_nbits-1:0] enq_ptr [2];
    logic [c_ptr_nbits-1:0] deq_ptr [2];
    logic [c_cnt_nbits-1:0] count   [2];
    logic [1:0]             full;
    logic [1:0]             out_val;
    logic [1:0]             out_rdy;
    logic [1:0]             enq_go;
    logic [1:0]             deq_go;

    function automatic logic [c_ptr_nbits-1:0] next_ptr(input logic [c_ptr_nbits-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // Ready looks only at fullness, never at the downstream ready, so there is no comb loop.
    always_comb begin
        out_rdy = {out_rdy_d2, out_rdy_d1};
        full    = '0;
        out_val = '0;
        for (int d = 0; d < 2; d++) begin
            full[d]    = (count[d] == c_full_cnt);
            out_val[d] = (count[d] != '0);
        end
        in_rdy    = !reset && !(in_domain ? full[1] : full[0]);
        enq_go[0] = in_val && in_rdy && !in_domain;
        enq_go[1] = in_val && in_rdy && in_domain;
        deq_go    = out_val & out_rdy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fclk <= 1'b0;
            for (int d = 0; d < 2; d++) begin
                enq_ptr[d] <= '0;
                deq_ptr[d] <= '0;
                count[d]   <= '0;
            end
        end else begin
            fclk <= !fclk;
            for (int d = 0; d < 2; d++) begin
                if (enq_go[d]) enq_ptr[d] <= next_ptr(enq_ptr[d]);
                if (deq_go[d]) deq_ptr[d] <= next_ptr(deq_ptr[d]);
                case ({enq_go[d], deq_go[d]})
                    2'b10:   count[d] <= count[d] + 1'b1;
                    2'b01:   count[d] <= count[d] - 1'b1;
                    default: count[d] <= count[d];
                endcase
            end
        end
    end

    // Storage is deliberately left out of reset; empty entries are masked by out_val.
    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (enq_go[d]) mem[d][enq_ptr[d]] <= in_msg;
        end
    end

    assign out_val_d1 = out_val[0];
    assign out_val_d2 = out_val[1];
    assign out_msg_d1 = mem[0][deq_ptr[0]];
    assign out_msg_d2 = mem[1][deq_ptr[1]];
    assign dest_d1    = out_msg_d1[p_msg_nbits-1 -: c_dest_nbits];
    assign dest_d2    = out_msg_d2[p_msg_nbits-1 -: c_dest_nbits];
    assign count_d1   = count[0];
    assign count_d2   = count[1];

endmodule

// File: tb/tb_plab4_net_router_input_queue_sep.sv
// Directed self-checking bench for the dual-domain router input queue.
// Expected values are hand-computed from the intended FIFO behaviour.
module tb_plab4_net_router_input_queue_sep;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [31:0] in_msg = '0;
    logic        in_domain = 1'b0;
    logic        out_val_d1, out_val_d2;
    logic        out_rdy_d1 = 1'b0;
    logic        out_rdy_d2 = 1'b0;
    logic [31:0] out_msg_d1, out_msg_d2;
    logic [2:0]  dest_d1, dest_d2;
    logic        fclk;
    logic [2:0]  count_d1, count_d2;

    int passed = 0;
    int total  = 0;

    plab4_net_router_input_queue_sep #(
        .p_msg_nbits(32), .p_num_routers(8), .p_num_entries(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_domain(in_domain),
        .out_val_d1(out_val_d1), .out_rdy_d1(out_rdy_d1), .out_msg_d1(out_msg_d1), .dest_d1(dest_d1),
        .out_val_d2(out_val_d2), .out_rdy_d2(out_rdy_d2), .out_msg_d2(out_msg_d2), .dest_d2(dest_d2),
        .fclk(fclk), .count_d1(count_d1), .count_d2(count_d2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_fclk;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_rdy !== 1'b0) $display("FAIL rst_in_rdy: got %b exp 0", in_rdy); else passed++;
        total++; if (out_val_d1 !== 1'b0 || out_val_d2 !== 1'b0) $display("FAIL rst_out_val: got %b%b exp 00", out_val_d1, out_val_d2); else passed++;
        @(negedge clk);
        reset = 1'b0;
        exp_fclk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (fclk !== exp_fclk) $display("FAIL fclk_seq%0d: got %b exp %b", i, fclk, exp_fclk); else passed++;
            total++; if (count_d1 !== 3'd0 || count_d2 !== 3'd0 || out_val_d1 !== 1'b0 || out_val_d2 !== 1'b0)
                $display("FAIL idle%0d: got cnt %0d/%0d val %b%b exp 0/0 00", i, count_d1, count_d2, out_val_d1, out_val_d2); else passed++;
            step();
            exp_fclk = ~exp_fclk;
        end
    endtask

    task automatic test_fill_d1();
        in_val = 1'b1;
        in_domain = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_msg = 32'hE000_0000 + 32'(k);
            total++; if (in_rdy !== 1'b1) $display("FAIL fill_rdy%0d: got %b exp 1", k, in_rdy); else passed++;
            if (k == 1) begin
                total++; if (out_val_d1 !== 1'b0) $display("FAIL no_bypass: got %b exp 0", out_val_d1); else passed++;
            end
            step();
        end
        total++; if (count_d1 !== 3'd4) $display("FAIL fill_count: got %0d exp 4", count_d1); else passed++;
        total++; if (in_rdy !== 1'b0) $display("FAIL full_rdy_d0: got %b exp 0", in_rdy); else passed++;
        in_domain = 1'b1;
        #1;
        total++; if (in_rdy !== 1'b1) $display("FAIL full_rdy_d1: got %b exp 1", in_rdy); else passed++;
        in_val = 1'b0;
        total++; if (out_msg_d1 !== 32'hE000_0001) $display("FAIL fill_head: got %h exp e0000001", out_msg_d1); else passed++;
        total++; if (dest_d1 !== 3'b111) $display("FAIL fill_dest: got %b exp 111", dest_d1); else passed++;
    endtask

    task automatic test_full_deq();
        in_val = 1'b1;
        in_domain = 1'b0;
        in_msg = 32'hE000_0005;
        out_rdy_d1 = 1'b1;
        #1;
        total++; if (in_rdy !== 1'b0) $display("FAIL fulldeq_rdy: got %b exp 0", in_rdy); else passed++;
        step();
        in_val = 1'b0;
        total++; if (count_d1 !== 3'd3) $display("FAIL fulldeq_count: got %0d exp 3", count_d1); else passed++;
        total++; if (out_msg_d1 !== 32'hE000_0002) $display("FAIL fulldeq_head: got %h exp e0000002", out_msg_d1); else passed++;
        for (int k = 3; k <= 4; k++) begin
            step();
            total++; if (out_msg_d1 !== 32'hE000_0000 + 32'(k)) $display("FAIL drain_head%0d: got %h exp %h", k, out_msg_d1, 32'hE000_0000 + 32'(k)); else passed++;
        end
        step();
        total++; if (count_d1 !== 3'd0 || out_val_d1 !== 1'b0) $display("FAIL drain_empty: got cnt %0d val %b exp 0 0", count_d1, out_val_d1); else passed++;
        step();
        total++; if (count_d1 !== 3'd0) $display("FAIL deq_when_empty: got %0d exp 0", count_d1); else passed++;
        out_rdy_d1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        in_val = 1'b1;
        in_domain = 1'b1;
        in_msg = 32'hA000_0000;
        step();
        total++; if (count_d2 !== 3'd1) $display("FAIL b2b_prime: got %0d exp 1", count_d2); else passed++;
        out_rdy_d2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_msg = 32'hA000_0000 + 32'(k);
            total++; if (out_msg_d2 !== 32'hA000_0000 + 32'(k - 1)) $display("FAIL b2b_head%0d: got %h exp %h", k, out_msg_d2, 32'hA000_0000 + 32'(k - 1)); else passed++;
            step();
            total++; if (count_d2 !== 3'd1) $display("FAIL b2b_count%0d: got %0d exp 1", k, count_d2); else passed++;
        end
        total++; if (out_msg_d2 !== 32'hA000_0005 || dest_d2 !== 3'b101) $display("FAIL b2b_final: got %h/%b exp a0000005/101", out_msg_d2, dest_d2); else passed++;
        total++; if (count_d1 !== 3'd0) $display("FAIL b2b_iso: got %0d exp 0", count_d1); else passed++;
        in_val = 1'b0;
        step();
        out_rdy_d2 = 1'b0;
        total++; if (count_d2 !== 3'd0) $display("FAIL b2b_drain: got %0d exp 0", count_d2); else passed++;
    endtask

    task automatic test_interleave();
        in_val = 1'b1;
        in_domain = 1'b0; in_msg = 32'h2000_00AA; step();
        in_domain = 1'b1; in_msg = 32'h4000_00BB; step();
        in_domain = 1'b0; in_msg = 32'h6000_00CC; step();
        in_val = 1'b0;
        in_domain = 1'bx;
        in_msg = 'x;
        step();
        total++; if (out_msg_d1 !== 32'h2000_00AA) $display("FAIL il_head_d1: got %h exp 200000aa", out_msg_d1); else passed++;
        total++; if (out_msg_d2 !== 32'h4000_00BB || dest_d2 !== 3'b010) $display("FAIL il_head_d2: got %h/%b exp 400000bb/010", out_msg_d2, dest_d2); else passed++;
        total++; if (count_d1 !== 3'd2 || count_d2 !== 3'd1) $display("FAIL il_counts: got %0d/%0d exp 2/1", count_d1, count_d2); else passed++;
        in_domain = 1'b0;
        in_msg = '0;
        out_rdy_d1 = 1'b1;
        step();
        total++; if (out_msg_d1 !== 32'h6000_00CC || dest_d1 !== 3'b011) $display("FAIL il_second: got %h/%b exp 600000cc/011", out_msg_d1, dest_d1); else passed++;
        step();
        out_rdy_d1 = 1'b0;
        total++; if (out_val_d1 !== 1'b0 || count_d2 !== 3'd1) $display("FAIL il_after: got val %b cnt_d2 %0d exp 0 1", out_val_d1, count_d2); else passed++;
    endtask

    task automatic test_reset_mid();
        in_val = 1'b1;
        in_domain = 1'b0;
        in_msg = 32'h1111_0001; step();
        in_msg = 32'h1111_0002; step();
        in_val = 1'b0;
        total++; if (count_d1 !== 3'd2) $display("FAIL rm_pre: got %0d exp 2", count_d1); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++; if (out_val_d1 !== 1'b0 || out_val_d2 !== 1'b0) $display("FAIL rm_val: got %b%b exp 00", out_val_d1, out_val_d2); else passed++;
        total++; if (fclk !== 1'b0 || in_rdy !== 1'b0) $display("FAIL rm_fclk_rdy: got %b/%b exp 0/0", fclk, in_rdy); else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (count_d1 !== 3'd0 || count_d2 !== 3'd0) $display("FAIL rm_count: got %0d/%0d exp 0/0", count_d1, count_d2); else passed++;
        in_val = 1'b1;
        in_msg = 32'h8000_0077;
        step();
        in_val = 1'b0;
        total++; if (fclk !== 1'b1 || count_d1 !== 3'd1 || out_msg_d1 !== 32'h8000_0077)
            $display("FAIL rm_post: got fclk %b cnt %0d head %h exp 1 1 80000077", fclk, count_d1, out_msg_d1); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill_d1();
        test_full_deq();
        test_back_to_back();
        test_interleave();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
